// File: rtl/parser_dispatch_pkg.sv
// Shared constants for the token dispatcher: default geometry and FSM state encoding.
// Imported by the dispatcher top and its helpers.
package parser_dispatch_pkg;

  localparam int NUM_PARSER_DEF = 6;
  localparam int TOKEN_W_DEF    = 64;
  localparam int COUNT_W        = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/parser_dispatch_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping at N-1 -> 0.
module rr_pick #(
  parameter int N  = 6,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] index
);

  // One spare bit so start + offset never overflows before the wrap subtract.
  logic [IW:0] pos;

  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, start} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && req[pos[IW-1:0]]) begin
        found = 1'b1;
        index = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/parser_dispatch.sv
// Pops preparsed tokens from a FWFT FIFO one at a time and hands each to the next
// ready parser in round-robin order; signals when a finished page has been fully dispatched.
module parser_dispatch
  import parser_dispatch_pkg::*;
#(
  parameter int NUM_PARSER = NUM_PARSER_DEF,
  parameter int TOKEN_W    = TOKEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tf_empty,
  input  logic [TOKEN_W-1:0]    tf_dout,
  output logic                  tf_rd,
  input  logic [NUM_PARSER-1:0] ps_ready,
  output logic [NUM_PARSER-1:0] ps_valid,
  output logic [TOKEN_W-1:0]    ps_data,
  input  logic                  page_input_finish,
  output logic                  page_dispatched,
  output logic [COUNT_W-1:0]    token_count
);

  localparam int PW = (NUM_PARSER > 1) ? $clog2(NUM_PARSER) : 1;

  logic [2:0]            state;
  logic [TOKEN_W-1:0]    hold_data;
  logic [NUM_PARSER-1:0] target;
  logic [PW-1:0]         rr_ptr;
  logic                  armed;
  count_t                count;

  logic                  pick_found;
  logic [PW-1:0]         pick_idx;
  logic [PW-1:0]         next_ptr;

  rr_pick #(
    .N  (NUM_PARSER),
    .IW (PW)
  ) u_rr_pick (
    .req   (ps_ready),
    .start (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign next_ptr = (pick_idx == PW'(NUM_PARSER - 1)) ? '0 : pick_idx + PW'(1);

  // Strobes are gated by rst_n so a reset landing in IDLE or SEND neither pops nor dispatches.
  assign tf_rd           = rst_n && (state == ST_IDLE) && !tf_empty;
  assign ps_valid        = (rst_n && (state == ST_SEND)) ? target : '0;
  assign page_dispatched = rst_n && (state == ST_DONE);
  assign token_count     = count;

  // The FIFO head advances on the pop edge, so the token is latched on that same edge.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && !tf_empty) hold_data <= tf_dout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ps_data <= '0;
      target  <= '0;
      rr_ptr  <= '0;
      armed   <= 1'b1;
      count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!page_input_finish) armed <= 1'b1;
          if (!tf_empty) begin
            state <= ST_LOAD;
          end else if (page_input_finish && armed) begin
            state <= ST_DONE;
            armed <= 1'b0;
          end
        end
        ST_LOAD: state <= ST_HOLD;
        ST_HOLD: begin
          // Target is frozen here; later ps_ready changes cannot redirect the token.
          if (pick_found) begin
            target  <= NUM_PARSER'(1) << pick_idx;
            ps_data <= hold_data;
            rr_ptr  <= next_ptr;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          count <= count + count_t'(1);
          state <= ST_IDLE;
        end
        ST_DONE: begin
          count <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parser_dispatch.sv
// Directed bench for parser_dispatch with a FWFT FIFO model and logged parser strobes.
module tb_parser_dispatch;

  localparam int NP = 6;
  localparam int TW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tf_empty;
  logic [TW-1:0] tf_dout;
  logic          tf_rd;
  logic [NP-1:0] ps_ready;
  logic [NP-1:0] ps_valid;
  logic [TW-1:0] ps_data;
  logic          page_input_finish;
  logic          page_dispatched;
  logic [15:0]   token_count;

  always #5 clk = ~clk;

  parser_dispatch #(
    .NUM_PARSER (NP),
    .TOKEN_W    (TW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .tf_empty          (tf_empty),
    .tf_dout           (tf_dout),
    .tf_rd             (tf_rd),
    .ps_ready          (ps_ready),
    .ps_valid          (ps_valid),
    .ps_data           (ps_data),
    .page_input_finish (page_input_finish),
    .page_dispatched   (page_dispatched),
    .token_count       (token_count)
  );

  logic [TW-1:0] fifo[$];
  logic [NP-1:0] pv_log[$];
  logic [TW-1:0] pd_log[$];
  int            pv_cyc[$];
  int            cyc;
  int            pulses;
  int            pulse_cyc;
  int            count_at_pulse;
  int            rd_seen;
  int            checks;
  int            failures;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    tf_empty = (fifo.size() == 0);
    tf_dout  = tf_empty ? '0 : fifo[0];
  endtask

  task automatic push(input logic [TW-1:0] v);
    fifo.push_back(v);
    refresh();
  endtask

  task automatic clear_logs();
    pv_log.delete();
    pd_log.delete();
    pv_cyc.delete();
    pulses  = 0;
    rd_seen = 0;
  endtask

  task automatic step();
    logic pop;
    @(negedge clk);
    pop = tf_rd;
    @(posedge clk);
    #1;
    cyc++;
    if (pop && fifo.size() > 0) void'(fifo.pop_front());
    refresh();
    if (ps_valid != '0) begin
      pv_log.push_back(ps_valid);
      pd_log.push_back(ps_data);
      pv_cyc.push_back(cyc);
    end
    if (page_dispatched) begin
      pulses++;
      pulse_cyc      = cyc;
      count_at_pulse = int'(token_count);
    end
    if (tf_rd) rd_seen++;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int i = 0; i < budget && pv_log.size() < n; i++) step();
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; pulse_cyc = 0; count_at_pulse = 0;
    clear_logs();
    rst_n = 1'b0; ps_ready = '0; page_input_finish = 1'b0;
    refresh();
    step(); step();
    chk("rst_tf_rd", tf_rd, 0);
    chk("rst_ps_valid", ps_valid, 0);
    chk("rst_ps_data", ps_data, 0);
    chk("rst_page_disp", page_dispatched, 0);
    chk("rst_count", token_count, 0);
    rst_n = 1'b1;
    step();

    // Seven tokens, all parsers ready: rotation and wrap back to parser 0.
    ps_ready = '1;
    for (int i = 0; i < 7; i++) push(64'h100 + 64'(i));
    run_until(7, 60);
    chk("rot_n", pv_log.size(), 7);
    if (pv_log.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("rot_v%0d", i), pv_log[i], 64'(6'b000001 << (i % 6)));
        chk($sformatf("rot_d%0d", i), pd_log[i], 64'h100 + 64'(i));
      end
      chk("rot_span", pv_cyc[6] - pv_cyc[0], 24);
    end
    step();
    chk("rot_count", token_count, 7);
    chk("rot_fifo", fifo.size(), 0);

    // Advance rr_ptr to 5, then only parser 3 ready: search wraps to 3.
    clear_logs();
    for (int i = 0; i < 4; i++) push(64'h200 + 64'(i));
    run_until(4, 40);
    chk("adv_n", pv_log.size(), 4);
    if (pv_log.size() == 4) chk("adv_last", pv_log[3], 6'b010000);
    step();
    clear_logs();
    ps_ready = 6'b001000;
    push(64'hA3);
    run_until(1, 20);
    chk("wrap_n", pv_log.size(), 1);
    if (pv_log.size() == 1) begin
      chk("wrap_v", pv_log[0], 6'b001000);
      chk("wrap_d", pd_log[0], 64'hA3);
    end
    step();
    // rr_ptr is now 4, so with everyone ready parser 4 wins next.
    clear_logs();
    ps_ready = '1;
    push(64'hA4);
    run_until(1, 20);
    chk("ptr4_v", (pv_log.size() == 1) ? pv_log[0] : '0, 6'b010000);
    step();
    chk("ptr4_count", token_count, 13);

    // Stall in HOLD with nobody ready and a second token waiting in the FIFO.
    clear_logs();
    ps_ready = '0;
    push(64'hB0);
    step(); step();
    push(64'hB1);
    rd_seen = 0;
    for (int i = 0; i < 20; i++) step();
    chk("stall_nv", pv_log.size(), 0);
    chk("stall_rd", rd_seen, 0);
    chk("stall_fifo", fifo.size(), 1);
    ps_ready = 6'b000001;
    step();
    chk("unstall_v", ps_valid, 6'b000001);
    chk("unstall_d", ps_data, 64'hB0);
    step();
    chk("unstall_off", ps_valid, 0);
    run_until(2, 20);
    chk("stall2_n", pv_log.size(), 2);
    if (pv_log.size() == 2) begin
      chk("stall2_v", pv_log[1], 6'b000001);
      chk("stall2_d", pd_log[1], 64'hB1);
    end
    step();
    chk("stall_count", token_count, 15);

    // Three tokens with finish raised at once: tokens first, then one pulse only.
    clear_logs();
    ps_ready = '1;
    for (int i = 0; i < 3; i++) push(64'hC0 + 64'(i));
    page_input_finish = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("page_nv", pv_log.size(), 3);
    chk("page_pulses", pulses, 1);
    if (pv_log.size() == 3) chk("page_after", pulse_cyc > pv_cyc[2], 1);
    chk("page_cnt_at", count_at_pulse, 18);
    chk("page_cnt_clr", token_count, 0);

    // Dropping finish in IDLE rearms the pulse.
    clear_logs();
    page_input_finish = 1'b0;
    step(); step();
    page_input_finish = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("rearm_pulses", pulses, 1);

    // Token and finish together in IDLE: dispatch precedes the pulse.
    clear_logs();
    page_input_finish = 1'b0;
    step(); step();
    push(64'hD0);
    page_input_finish = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("prio_nv", pv_log.size(), 1);
    chk("prio_pulses", pulses, 1);
    if (pv_log.size() == 1) chk("prio_order", pulse_cyc > pv_cyc[0], 1);
    page_input_finish = 1'b0;
    step();

    // Reset during HOLD discards the token.
    clear_logs();
    ps_ready = '0;
    push(64'hE0);
    step(); step(); step();
    rst_n = 1'b0;
    ps_ready = '1;
    step();
    chk("rhold_v", ps_valid, 0);
    chk("rhold_d", ps_data, 0);
    chk("rhold_rd", tf_rd, 0);
    chk("rhold_cnt", token_count, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("rhold_nv", pv_log.size(), 0);

    // Reset asserted while SEND is showing its strobe kills it immediately.
    clear_logs();
    push(64'hE1);
    run_until(1, 20);
    chk("rsend_seen", pv_log.size(), 1);
    rst_n = 1'b0;
    #1;
    chk("rsend_now", ps_valid, 0);
    step();
    chk("rsend_after", ps_valid, 0);
    chk("rsend_data", ps_data, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("rsend_nv", pv_log.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
